// File: rtl/pm_pkg.sv
// Shared program-memory constants: geometry defaults, byte-lane order and writer FSM encoding.
// Pure declarations; no timing or flow control of its own.
package pm_pkg;

    localparam int PM_WORD_SIZE = 16;
    localparam int PM_ADDR_W    = 13;
    localparam int PM_PAGE_W    = 6;

    // First byte of each stream pair lands in bits [7:0].
    localparam logic PM_LSB_FIRST = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_LASTWR = 3'd2;
    localparam logic [2:0] ST_VERIFY = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;

endpackage

// File: rtl/pm_word_assembler.sv
// Pairs stream bytes into 16-bit PM words; the word/strobe appear combinationally on the odd accept.
// No backpressure of its own: accept_i is the caller's valid&ready handshake.
module pm_word_assembler
    import pm_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    accept_i,
    input  logic [7:0]              byte_i,
    output logic [PM_WORD_SIZE-1:0] word_o,
    output logic                    word_stb_o
);

    logic       r_phase;
    logic [7:0] r_low;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_phase <= 1'b0;
            r_low   <= 8'h00;
        end else if (accept_i) begin
            r_phase <= ~r_phase;
            if (!r_phase) r_low <= byte_i;
        end
    end

    assign word_stb_o = accept_i & r_phase;
    assign word_o     = PM_LSB_FIRST ? {byte_i, r_low} : {r_low, byte_i};

endmodule

// File: rtl/pm_page_writer.sv
// Streams one page of bytes into PM as words, reads it back and compares 16-bit checksums.
// One write per odd byte, registered (1 cycle); byte_ready_o only in FILL, source stalls freely.
module pm_page_writer
    import pm_pkg::*;
#(
    parameter int WORD_SIZE = PM_WORD_SIZE,
    parameter int ADDR_W    = PM_ADDR_W,
    parameter int PAGE_W    = PM_PAGE_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [ADDR_W-PAGE_W-1:0] page_i,
    input  logic                 abort_i,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    output logic [ADDR_W-1:0]    pm_addr_o,
    output logic [WORD_SIZE-1:0] pm_data_o,
    output logic                 pm_we_o,
    input  logic [WORD_SIZE-1:0] pm_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int PG_W = ADDR_W - PAGE_W;

    logic [2:0]           r_state;
    logic [PG_W-1:0]      r_page;
    logic [PAGE_W-1:0]    r_idx;
    logic [WORD_SIZE-1:0] r_wr_sum;
    logic [WORD_SIZE-1:0] r_rd_sum;
    logic [ADDR_W-1:0]    r_pm_addr;
    logic [WORD_SIZE-1:0] r_pm_data;
    logic                 r_pm_we;
    logic                 r_error;

    logic                 w_busy;
    logic                 w_abort;
    logic                 w_start;
    logic                 w_byte_rdy;
    logic                 w_accept;
    logic                 w_check;
    logic                 w_chk_err;
    logic                 w_word_stb;
    logic [WORD_SIZE-1:0] w_word;
    logic [WORD_SIZE-1:0] w_rd_final;
    logic [PAGE_W-1:0]    w_idx_nxt;
    logic                 w_idx_last;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_abort    = w_busy & abort_i;
    assign w_start    = (r_state == ST_IDLE) & start_i;
    assign w_byte_rdy = (r_state == ST_FILL) & ~abort_i;
    assign w_accept   = byte_valid_i & w_byte_rdy;
    assign w_idx_nxt  = r_idx + PAGE_W'(1);
    assign w_idx_last = &r_idx;
    assign w_check    = (r_state == ST_CHECK);
    assign w_rd_final = r_rd_sum + pm_data_i;
    assign w_chk_err  = (w_rd_final != r_wr_sum);

    pm_word_assembler u_asm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (w_start | w_abort),
        .accept_i   (w_accept),
        .byte_i     (byte_i),
        .word_o     (w_word),
        .word_stb_o (w_word_stb)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_page    <= '0;
            r_idx     <= '0;
            r_wr_sum  <= '0;
            r_rd_sum  <= '0;
            r_pm_addr <= '0;
            r_pm_data <= '0;
            r_pm_we   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_pm_we <= 1'b0;
            if (w_abort) begin
                r_state <= ST_IDLE;
                r_error <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: if (start_i) begin
                        r_state  <= ST_FILL;
                        r_page   <= page_i;
                        r_idx    <= '0;
                        r_wr_sum <= '0;
                        r_rd_sum <= '0;
                        r_error  <= 1'b0;
                    end
                    ST_FILL: if (w_word_stb) begin
                        r_pm_addr <= {r_page, r_idx};
                        r_pm_data <= w_word;
                        r_pm_we   <= 1'b1;
                        r_wr_sum  <= r_wr_sum + w_word;
                        r_idx     <= w_idx_nxt;
                        if (w_idx_last) r_state <= ST_LASTWR;
                    end
                    ST_LASTWR: begin
                        r_state   <= ST_VERIFY;
                        r_idx     <= '0;
                        r_pm_addr <= {r_page, {PAGE_W{1'b0}}};
                    end
                    // Read data trails its address by one cycle, so idx 0 has nothing to add yet.
                    ST_VERIFY: begin
                        if (r_idx != '0) r_rd_sum <= w_rd_final;
                        if (w_idx_last) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_pm_addr <= {r_page, w_idx_nxt};
                        end
                    end
                    ST_CHECK: begin
                        r_rd_sum <= w_rd_final;
                        r_error  <= w_chk_err;
                        r_state  <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign byte_ready_o = w_byte_rdy;
    assign pm_addr_o    = r_pm_addr;
    assign pm_data_o    = r_pm_data;
    assign pm_we_o      = r_pm_we;
    assign busy_o       = w_busy;
    assign done_o       = w_check & ~abort_i;
    assign error_o      = r_error | (done_o & w_chk_err);

endmodule

// File: doc/pm_page_writer.md
Name: pm_page_writer

Overview:
Writer side of the CPU-modifiable program memory. It takes a byte stream, for example from the bootloader UART receiver, and assembles little-endian 16-bit words. It writes one full page into the program memory through its addr/we/data port, then reads the page back and compares checksums. It sits between the byte source and the PM write port; the CPU is held off the port while busy_o=1.

Parameters:
WORD_SIZE, 16, PM word width; fixed at 16 (two bytes per word).
ADDR_W, 13, PM word-address width.
PAGE_W, 6, log2 of words per page (64 words = 128 bytes).

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  synchronous reset, active high.
start_i  in  1  begin a page transfer; ignored unless IDLE.
page_i  in  ADDR_W-PAGE_W  page number, latched on accepted start_i.
abort_i  in  1  cancel the current transfer.
byte_i  in  8  stream byte.
byte_valid_i  in  1  byte_i valid.
byte_ready_o  out  1  byte accepted when valid&ready.
pm_addr_o  out  ADDR_W  PM word address.
pm_data_o  out  WORD_SIZE  PM write data.
pm_we_o  out  1  PM write enable.
pm_data_i  in  WORD_SIZE  PM read data; valid the cycle after pm_addr_o is presented.
busy_o  out  1  transfer in progress (states other than IDLE).
done_o  out  1  one-cycle pulse at end of verify.
error_o  out  1  checksum mismatch or abort; held until the next accepted start_i.

Behaviour:
- Reset (sync, rst_i=1): state IDLE; byte_ready_o, pm_we_o, busy_o, done_o and error_o all 0; pm_addr_o=0; pm_data_o=0; word index, byte phase, wr_sum and rd_sum cleared. Reset overrides every other input, including mid-transfer; a write in flight is dropped.
- States: IDLE, FILL, LASTWR, VERIFY, CHECK.
- IDLE -> FILL when start_i=1:
  - latch page_i;
  - clear index, byte phase, both sums and error_o.
- FILL: byte_ready_o=1.
  - Even-phase accept stores the low byte.
  - Odd-phase accept registers pm_addr_o={page,idx}, pm_data_o={byte_i,low}, and pm_we_o=1 for exactly the next cycle.
  - On that same accept, wr_sum += word (mod 2^16) and idx increments.
  - Accepting the odd byte of idx=2^PAGE_W-1 -> LASTWR, with byte_ready_o=0 from the next cycle.
  - Bytes with valid=0 stall indefinitely; there is no timeout.
- LASTWR: one cycle in which the final pm_we_o=1 is issued -> VERIFY, idx=0.
- VERIFY: pm_we_o=0.
  - pm_addr_o={page,idx} presented one per cycle, idx 0..2^PAGE_W-1.
  - pm_data_i is added to rd_sum one cycle after each address.
  - After the last address is issued -> CHECK.
- CHECK: add the final pm_data_i; error_o=(rd_sum!=wr_sum); done_o=1 for this one cycle -> IDLE.
- Read latency: 1 cycle. This matches the rising-edge PM; a falling-edge PM satisfies it trivially.
- abort_i=1 in any non-IDLE state:
  - next cycle IDLE, error_o=1, done_o=0;
  - no write issued after the abort cycle;
  - a byte presented in the abort cycle is not accepted (byte_ready_o=0 when abort_i=1).
- start_i while busy: ignored. start_i and abort_i both 1 in IDLE: start wins.
- Address wrap: idx is PAGE_W bits and never carries into the page field.
- Sums: 16-bit unsigned modular addition; only the 16-bit sum is compared.

Decomposition:
- Shared package pm_pkg:
  - state encoding constants;
  - PM_WORD_SIZE=16 and PM_ADDR_W=13 defaults, shared with the PM instantiations;
  - byte-lane order constant (LSB first).
- One natural sub-module: pm_word_assembler, covering byte-phase toggle, low-byte register and word/strobe output. The FSM, address counter and checksum stay in the top.

Test Plan:
1. Reset, then start_i with page_i=3, bytes 0x00..0x7F with valid always high:
   - 64 single-cycle writes to addresses 0x0C0..0x0FF;
   - word k = {2k+1,2k} (0x0100, 0x0302, ..., 0x7F7E);
   - wr_sum=0x0FC0;
   - behavioural PM model -> done_o pulse, error_o=0.
2. Same stimulus, but the PM model corrupts address 0x0C5 on read (XOR 0x0001) -> done_o pulse, error_o=1.
3. valid toggled 1/0 with random gaps (up to 7 cycles) -> identical PM contents and writes as scenario 1; pm_we_o never asserted on even-phase accepts.
4. abort_i asserted after 37 accepted bytes:
   - 18 writes only, next cycle IDLE;
   - error_o=1, no done_o, byte_ready_o=0.
   - A new start_i then clears error_o.
5. rst_i mid-VERIFY -> all outputs 0 next cycle; start_i pulses during FILL are ignored (page latch unchanged).
6. page_i=127 (last page), full transfer -> addresses 0x1FC0..0x1FFF with no wrap into page 0; done_o=1, error_o=0.
